sram_client_arbiter: RTL and testbench

- Sits directly upstream of the SRAM controller. Arbitrates two game-logic clients (A, B) onto its single request interface.
- Sequences each access to match the controller's timing: write pulse then wait for ready; reads are combinational, so the address is held for a fixed time before data is sampled.
- Also forwards full-clear and mark-clear commands, and gives each client a clean req/ack handshake with registered read data.

---
 rtl/sram_client_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_client_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_client_arbiter.sv
// Two-client arbiter in front of the SRAM controller: sequences writes, timed reads
// and clear commands onto the single controller port, one transaction at a time.
module sram_client_arbiter #(
   parameter int DEPTH     = 19,
   parameter int READ_WAIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [DEPTH:0]   a_addr,
   input  logic [15:0]      a_wdata,
   output logic             a_ack,
   output logic [15:0]      a_rdata,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [DEPTH:0]   b_addr,
   input  logic [15:0]      b_wdata,
   output logic             b_ack,
   output logic [15:0]      b_rdata,
   input  logic             clr_req,
   input  logic             clr_mark,
   output logic             clr_ack,
   output logic [DEPTH:0]   mem_addr,
   output logic             mem_write_en,
   output logic [15:0]      mem_data_in,
   input  logic [15:0]      mem_data_out,
   input  logic             mem_ready,
   output logic             mem_rst,
   output logic             mem_clean_mark
);

   // Handshake: a requester raises req (level) with stable fields and holds it until
   // its ack pulses for one cycle; a req still high in the cycle after ack is a new request.
   typedef enum logic [2:0] {
      S_SETTLE, S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_WAIT, S_CLR_ISSUE, S_CLR_WAIT, S_DONE
   } state_t;

   localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);

   state_t     state;
   logic [1:0] settle_cnt;
   logic [3:0] rd_cnt;
   logic       rr_b;
   logic       owner_b;
   logic       grant_a;
   logic       grant_b;

   always_comb begin
      grant_a = a_req && (!b_req || !rr_b);
      grant_b = b_req && !grant_a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_SETTLE;
         settle_cnt     <= 2'd0;
         rd_cnt         <= 4'd0;
         rr_b           <= 1'b0;
         owner_b        <= 1'b0;
         a_ack          <= 1'b0;
         b_ack          <= 1'b0;
         clr_ack        <= 1'b0;
         a_rdata        <= 16'h0;
         b_rdata        <= 16'h0;
         mem_addr       <= '0;
         mem_data_in    <= 16'h0;
         mem_write_en   <= 1'b0;
         mem_rst        <= 1'b0;
         mem_clean_mark <= 1'b0;
      end else begin
         a_ack          <= 1'b0;
         b_ack          <= 1'b0;
         clr_ack        <= 1'b0;
         mem_write_en   <= 1'b0;
         mem_rst        <= 1'b0;
         mem_clean_mark <= 1'b0;
         case (state)
            S_SETTLE: begin
               if (settle_cnt == 2'd2) state <= S_IDLE;
               else                    settle_cnt <= settle_cnt + 2'd1;
            end
            S_IDLE: begin
               if (clr_req) begin
                  mem_rst        <= !clr_mark;
                  mem_clean_mark <= clr_mark;
                  state          <= S_CLR_ISSUE;
               end else if (grant_a || grant_b) begin
                  owner_b     <= grant_b;
                  rr_b        <= grant_a;
                  mem_addr    <= grant_a ? a_addr  : b_addr;
                  mem_data_in <= grant_a ? a_wdata : b_wdata;
                  rd_cnt      <= 4'd0;
                  if (grant_a ? a_we : b_we) begin
                     mem_write_en <= 1'b1;
                     state        <= S_WR_ISSUE;
                  end else begin
                     state <= S_RD_WAIT;
                  end
               end
            end
            S_WR_ISSUE: state <= S_WR_WAIT;
            S_WR_WAIT: begin
               if (mem_ready) begin
                  a_ack <= !owner_b;
                  b_ack <= owner_b;
                  state <= S_DONE;
               end
            end
            S_RD_WAIT: begin
               // The controller reads combinationally; sample only once the address has settled.
               if (rd_cnt == RD_LAST) begin
                  if (owner_b) b_rdata <= mem_data_out;
                  else         a_rdata <= mem_data_out;
                  a_ack <= !owner_b;
                  b_ack <= owner_b;
                  state <= S_DONE;
               end else begin
                  rd_cnt <= rd_cnt + 4'd1;
               end
            end
            S_CLR_ISSUE: state <= S_CLR_WAIT;
            S_CLR_WAIT: begin
               if (mem_ready) begin
                  clr_ack <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_SETTLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_client_arbiter.sv
// Directed bench for sram_client_arbiter: a small controller model plus an event
// scoreboard checking strobes and acks in the order they must appear.
module tb_sram_client_arbiter;
   localparam int DEPTH     = 19;
   localparam int READ_WAIT = 2;

   localparam logic [3:0] K_WE     = 4'd1;
   localparam logic [3:0] K_ACKA   = 4'd2;
   localparam logic [3:0] K_ACKB   = 4'd3;
   localparam logic [3:0] K_CLRACK = 4'd4;
   localparam logic [3:0] K_RST    = 4'd5;
   localparam logic [3:0] K_MARK   = 4'd6;

   logic             clk, rst;
   logic             a_req, a_we, a_ack;
   logic [DEPTH:0]   a_addr;
   logic [15:0]      a_wdata, a_rdata;
   logic             b_req, b_we, b_ack;
   logic [DEPTH:0]   b_addr;
   logic [15:0]      b_wdata, b_rdata;
   logic             clr_req, clr_mark, clr_ack;
   logic [DEPTH:0]   mem_addr;
   logic             mem_write_en, mem_ready, mem_rst, mem_clean_mark;
   logic [15:0]      mem_data_in, mem_data_out;

   logic [39:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [15:0]    mem_model [0:1023];
   int             rdy_cnt = 0;
   int             hold = 0;
   logic [DEPTH:0] last_addr = '0;

   sram_client_arbiter #(.DEPTH(DEPTH), .READ_WAIT(READ_WAIT)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .clr_req(clr_req), .clr_mark(clr_mark), .clr_ack(clr_ack),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .mem_ready(mem_ready),
      .mem_rst(mem_rst), .mem_clean_mark(mem_clean_mark)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [39:0] ev(input logic [3:0] k, input logic [19:0] a, input logic [15:0] d);
      return {k, a, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic sb_compare(input string name, input logic [39:0] obs);
      logic [39:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event %h, nothing expected", name, obs);
      end else begin
         e = exp_q.pop_front();
         if (obs !== e) begin
            errors++;
            $display("FAIL %s: got event %h expected %h", name, obs, e);
         end
      end
   endtask

   // controller model: write/clear ready after fixed delays, read data valid only
   // after the address has been stable for READ_WAIT cycles
   initial begin
      mem_ready    = 1'b0;
      mem_data_out = 16'h0BAD;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) mem_ready = 1'b1;
         end
         if (mem_write_en) begin
            mem_model[mem_addr[9:0]] = mem_data_in;
            rdy_cnt = 2;
         end
         if (mem_rst || mem_clean_mark) rdy_cnt = 6;
         if (mem_addr != last_addr) begin
            hold      = 1;
            last_addr = mem_addr;
         end else if (hold < 100) begin
            hold++;
         end
         mem_data_out = (hold >= READ_WAIT) ? mem_model[mem_addr[9:0]] : 16'h0BAD;
      end
   end

   // monitor: every strobe/ack is popped against the expected queue
   always @(negedge clk) begin
      int n;
      n = $countones({a_ack, b_ack, clr_ack, mem_write_en, mem_rst, mem_clean_mark});
      if (n > 0) check("one_event_per_cycle", n, 1);
      if (a_ack)          sb_compare("a_ack", ev(K_ACKA, 20'h0, a_rdata));
      if (b_ack)          sb_compare("b_ack", ev(K_ACKB, 20'h0, b_rdata));
      if (clr_ack)        sb_compare("clr_ack", ev(K_CLRACK, 20'h0, 16'h0));
      if (mem_write_en)   sb_compare("mem_write_en", ev(K_WE, mem_addr, mem_data_in));
      if (mem_rst)        sb_compare("mem_rst", ev(K_RST, 20'h0, 16'h0));
      if (mem_clean_mark) sb_compare("mem_clean_mark", ev(K_MARK, 20'h0, 16'h0));
   end

   // driver tasks
   task automatic drive_a(input logic we, input logic [19:0] addr, input logic [15:0] wd);
      int n;
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
      n = 0;
      do begin @(negedge clk); n++; end while (!a_ack && n < 300);
      if (!a_ack) begin
         checks++; errors++;
         $display("FAIL a_ack_timeout: got no ack after %0d cycles, expected ack", n);
      end
      a_req = 1'b0;
   endtask

   task automatic drive_b(input logic we, input logic [19:0] addr, input logic [15:0] wd);
      int n;
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
      n = 0;
      do begin @(negedge clk); n++; end while (!b_ack && n < 300);
      if (!b_ack) begin
         checks++; errors++;
         $display("FAIL b_ack_timeout: got no ack after %0d cycles, expected ack", n);
      end
      b_req = 1'b0;
   endtask

   task automatic drive_clr(input logic mark);
      int n;
      clr_req = 1'b1; clr_mark = mark;
      n = 0;
      do begin @(negedge clk); n++; end while (!clr_ack && n < 300);
      if (!clr_ack) begin
         checks++; errors++;
         $display("FAIL clr_ack_timeout: got no ack after %0d cycles, expected ack", n);
      end
      clr_req = 1'b0;
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 1024; i++) mem_model[i] = 16'h0;
      mem_model[10'h034] = 16'h5A5A;
      rst = 1'b1;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = 16'h0;
      clr_req = 1'b0; clr_mark = 1'b0;
      // A requests a write from cycle 0, through reset and settle
      a_req = 1'b1; a_we = 1'b1; a_addr = 20'h00012; a_wdata = 16'hBEEF;
      exp_q.push_back(ev(K_WE, 20'h00012, 16'hBEEF));
      exp_q.push_back(ev(K_ACKA, 20'h0, 16'h0));

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_acks", {a_ack, b_ack, clr_ack}, 0);
      check("rst_strobes", {mem_write_en, mem_rst, mem_clean_mark}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data_in", mem_data_in, 0);
      check("rst_a_rdata", a_rdata, 0);
      check("rst_b_rdata", b_rdata, 0);
      rst = 1'b0;

      // settle window: grant in cycle 3, write strobe in cycle 4
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!mem_write_en && cyc < 50);
      check("first_issue_cycle", cyc, 4);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!a_ack && cyc < 50);
      check("write_issue_to_ack", cyc, 3);
      a_req = 1'b0;

      // B read of 0x00012, controller now holding 0x1234 there
      mem_model[10'h012] = 16'h1234;
      exp_q.push_back(ev(K_ACKB, 20'h0, 16'h1234));
      drive_b(1'b0, 20'h00012, 16'h0);
      check("b_rdata_after_read", b_rdata, 16'h1234);
      check("a_rdata_unchanged", a_rdata, 16'h0);

      // contention, rr back at A: grant order A,B,A,B
      exp_q.push_back(ev(K_WE, 20'h00100, 16'h1111));
      exp_q.push_back(ev(K_ACKA, 20'h0, 16'h0));
      exp_q.push_back(ev(K_ACKB, 20'h0, 16'h5A5A));
      exp_q.push_back(ev(K_ACKA, 20'h0, 16'h1111));
      exp_q.push_back(ev(K_WE, 20'h00200, 16'h2222));
      exp_q.push_back(ev(K_ACKB, 20'h0, 16'h5A5A));
      fork
         begin
            drive_a(1'b1, 20'h00100, 16'h1111);
            drive_a(1'b0, 20'h00100, 16'h0);
         end
         begin
            drive_b(1'b0, 20'h00034, 16'h0);
            drive_b(1'b1, 20'h00200, 16'h2222);
         end
      join
      check("a_rdata_contention", a_rdata, 16'h1111);
      check("b_rdata_contention", b_rdata, 16'h5A5A);

      // full clear beats a simultaneous A request
      exp_q.push_back(ev(K_RST, 20'h0, 16'h0));
      exp_q.push_back(ev(K_CLRACK, 20'h0, 16'h0));
      exp_q.push_back(ev(K_WE, 20'h00300, 16'h3333));
      exp_q.push_back(ev(K_ACKA, 20'h0, 16'h1111));
      fork
         drive_clr(1'b0);
         drive_a(1'b1, 20'h00300, 16'h3333);
      join

      // mark-only clear
      exp_q.push_back(ev(K_MARK, 20'h0, 16'h0));
      exp_q.push_back(ev(K_CLRACK, 20'h0, 16'h0));
      drive_clr(1'b1);

      // abort in WR_WAIT: no ack, late ready ignored, held request replays after settle
      exp_q.push_back(ev(K_WE, 20'h00400, 16'h4444));
      fork
         drive_a(1'b1, 20'h00400, 16'h4444);
         begin
            int c;
            c = 0;
            do begin @(negedge clk); c++; end while (!mem_write_en && c < 50);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_q.push_back(ev(K_WE, 20'h00400, 16'h4444));
            exp_q.push_back(ev(K_ACKA, 20'h0, 16'h0));
            c = 0;
            do begin @(negedge clk); c++; end while (!mem_write_en && c < 50);
            check("reissue_after_abort", c, 4);
         end
      join
      check("a_rdata_after_abort", a_rdata, 16'h0);

      cyc = 0;
      while (exp_q.size() != 0 && cyc < 100) begin @(negedge clk); cyc++; end
      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
